// File: rtl/dir_validator.sv
// dir_validator: walks the board RAM from an origin cell along one direction
// and reports whether a run of opponent pieces is capped by an own piece.
module dir_validator #(
  parameter int ADDR_W    = 7,
  parameter int CELL_W    = 2,
  parameter int LAST_ADDR = 99,
  parameter int MAX_CELLS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld,
  input  logic              enable,
  input  logic [ADDR_W-1:0] origin_addr_i,
  input  logic [CELL_W-1:0] player_i,
  input  logic [4:0]        step_in,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [CELL_W-1:0] mem_data_i,
  output logic              s_done_o,
  output logic              dir_status_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Two extra bits: one to keep cur non-negative, one sign bit for the sum.
  localparam int NXT_W = ADDR_W + 2;
  localparam logic [NXT_W-1:0]  LAST_NXT  = NXT_W'(LAST_ADDR);
  localparam logic [3:0]        MAX_NCELL = 4'(MAX_CELLS);
  localparam logic [CELL_W-1:0] BLACK     = CELL_W'(1);
  localparam logic [CELL_W-1:0] WHITE     = CELL_W'(2);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_cur;
  logic [4:0]        r_step;
  logic [CELL_W-1:0] r_plyr;
  logic [3:0]        r_cnt;
  logic [3:0]        r_ncell;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_done;
  logic              r_status;

  logic [NXT_W-1:0]  w_nxt;
  logic              w_plyr_ok;
  logic              w_stop;
  logic              w_issue;

  // Next address candidate and the conditions that end the walk before a read.
  always_comb begin
    w_nxt     = {2'b00, r_cur} + {{(NXT_W-5){r_step[4]}}, r_step};
    w_plyr_ok = (r_plyr == BLACK) || (r_plyr == WHITE);
    w_stop    = w_nxt[NXT_W-1] || (w_nxt > LAST_NXT) ||
                (r_ncell == MAX_NCELL) || !w_plyr_ok;
    w_issue   = (r_state == S_ADDR) && !w_stop;
  end

  // The read is issued combinationally in ADDR so data returns during CHECK.
  assign rd_en_o      = w_issue;
  assign rd_addr_o    = w_issue ? w_nxt[ADDR_W-1:0] : r_rd_addr;
  assign s_done_o     = r_done;
  assign dir_status_o = r_status;

  // Walk FSM and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cur     <= '0;
      r_step    <= '0;
      r_plyr    <= '0;
      r_cnt     <= '0;
      r_ncell   <= '0;
      r_rd_addr <= '0;
      r_done    <= 1'b0;
      r_status  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // ld lands in the registers at this edge, so an enable in the same
          // cycle already walks with the freshly loaded values.
          if (ld) begin
            r_cur  <= origin_addr_i;
            r_step <= step_in;
            r_plyr <= player_i;
          end
          if (enable) begin
            r_cnt    <= '0;
            r_ncell  <= '0;
            r_status <= 1'b0;
            r_state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_stop) begin
            r_status <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cur     <= w_nxt[ADDR_W-1:0];
            r_rd_addr <= w_nxt[ADDR_W-1:0];
            r_ncell   <= r_ncell + 4'd1;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (mem_data_i == ~r_plyr) begin
            if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
            r_state <= S_ADDR;
          end else begin
            r_status <= (mem_data_i == r_plyr) && (r_cnt != 4'd0);
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
